vga_pattern_ctrl_module: RTL and testbench

Pixel-colour stage directly downstream of the 800x600@60 VGA sync generator. It consumes the sync generator's ready flag, column/row addresses and HSYNC/VSYNC, and produces registered RGB565 with sync outputs re-aligned to the colour. It provides three test patterns (colour bars, grid, bouncing square). A key pulse selects the pattern, and the change is applied only at a frame boundary, so a frame never tears.

---
 rtl/vga_pattern_ctrl_module.sv | 100 ++++++++++
 tb/tb_vga_pattern_ctrl_module.sv | 139 +++++++++++++
 2 files changed

// File: rtl/vga_pattern_ctrl_module.sv
// vga_pattern_ctrl_module: registered RGB565 test-pattern stage with frame-aligned pattern switching
module vga_pattern_ctrl_module #(
    parameter logic [10:0] H_ACT = 11'd800,
    parameter logic [10:0] V_ACT = 11'd600,
    parameter logic [10:0] SQ    = 11'd64,
    parameter logic [10:0] STEP  = 11'd2,
    parameter logic [10:0] BAR_W = 11'd100
) (
    input  logic        vga_clk,
    input  logic        rst_n,
    input  logic        Ready_Sig,
    input  logic [10:0] Column_Addr_Sig,
    input  logic [10:0] Row_Addr_Sig,
    input  logic        HSYNC_Sig,
    input  logic        VSYNC_Sig,
    input  logic        Key_Pulse_Sig,
    output logic [4:0]  Red_Sig,
    output logic [5:0]  Green_Sig,
    output logic [4:0]  Blue_Sig,
    output logic        HSYNC_Out_Sig,
    output logic        VSYNC_Out_Sig,
    output logic [1:0]  Mode_Sig
);
    typedef enum logic [1:0] {BAR = 2'd0, GRID = 2'd1, SQUARE = 2'd2, BAD = 2'd3} mode_t;
    localparam logic [10:0] X_MAX = H_ACT - SQ;
    localparam logic [10:0] Y_MAX = V_ACT - SQ;
    mode_t       mode_q;
    logic        pending_q, vs_prev_q, hs_q, vs_q;
    logic        dx_q, dy_q, dx_d, dy_d, x_hit, y_hit;
    logic [10:0] x_q, y_q, x_d, y_d;
    logic [15:0] rgb_q, rgb_d;
    logic [2:0]  bar_idx;
    logic        on_grid, in_sq;
    wire         tick    = vs_prev_q & ~VSYNC_Sig;
    wire         advance = tick & (pending_q | Key_Pulse_Sig);
    // square bounces per axis: clamp to the wall and reverse once reached
    assign x_hit = dx_q ? (x_q + STEP >= X_MAX) : (x_q <= STEP);
    assign y_hit = dy_q ? (y_q + STEP >= Y_MAX) : (y_q <= STEP);
    assign x_d   = !tick ? x_q : x_hit ? (dx_q ? X_MAX : 11'd0) : (dx_q ? x_q + STEP : x_q - STEP);
    assign y_d   = !tick ? y_q : y_hit ? (dy_q ? Y_MAX : 11'd0) : (dy_q ? y_q + STEP : y_q - STEP);
    assign dx_d  = (tick & x_hit) ? ~dx_q : dx_q;
    assign dy_d  = (tick & y_hit) ? ~dy_q : dy_q;
    // bar index by counting crossed bar boundaries, avoiding a divider
    always_comb begin
        bar_idx = 3'd0;
        for (int k = 1; k < 8; k++) bar_idx = bar_idx + 3'(Column_Addr_Sig >= BAR_W * 11'(k));
    end
    // next pixel colour from current address, mode and square position
    always_comb begin
        on_grid = (Column_Addr_Sig[5:0] == 6'd0) || (Row_Addr_Sig[5:0] == 6'd0) ||
                  (Column_Addr_Sig == H_ACT - 11'd1) || (Row_Addr_Sig == V_ACT - 11'd1);
        in_sq   = (Column_Addr_Sig >= x_q) && (Column_Addr_Sig < x_q + SQ) &&
                  (Row_Addr_Sig >= y_q) && (Row_Addr_Sig < y_q + SQ);
        rgb_d   = !Ready_Sig        ? 16'h0000 :
                  (mode_q == BAR)   ? {{5{~bar_idx[1]}}, {6{~bar_idx[2]}}, {5{~bar_idx[0]}}} :
                  (mode_q == GRID)  ? {16{on_grid}} :
                  (mode_q == SQUARE)? (in_sq ? 16'hF800 : 16'h001F) : 16'h0000;
    end
    // colour, re-aligned syncs, frame-edge detector and square position
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            rgb_q     <= 16'h0000;
            hs_q      <= 1'b1;
            vs_q      <= 1'b1;
            vs_prev_q <= 1'b1;
            x_q       <= 11'd0;
            y_q       <= 11'd0;
            dx_q      <= 1'b1;
            dy_q      <= 1'b1;
        end else begin
            rgb_q     <= rgb_d;
            hs_q      <= HSYNC_Sig;
            vs_q      <= VSYNC_Sig;
            vs_prev_q <= VSYNC_Sig;
            x_q       <= x_d;
            y_q       <= y_d;
            dx_q      <= dx_d;
            dy_q      <= dy_d;
        end
    end
    // pattern FSM: key requests are held until the next frame tick
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            mode_q    <= BAR;
            pending_q <= 1'b0;
        end else begin
            pending_q <= tick ? 1'b0 : (pending_q | Key_Pulse_Sig);
            case (mode_q)
                BAR:     if (advance) mode_q <= GRID;
                GRID:    if (advance) mode_q <= SQUARE;
                SQUARE:  if (advance) mode_q <= BAR;
                default: mode_q <= BAR;
            endcase
        end
    end
    assign {Red_Sig, Green_Sig, Blue_Sig} = rgb_q;
    assign HSYNC_Out_Sig = hs_q;
    assign VSYNC_Out_Sig = vs_q;
    assign Mode_Sig      = mode_q;
endmodule

// File: tb/tb_vga_pattern_ctrl_module.sv
// tb_vga_pattern_ctrl_module: scoreboard bench with a behavioural pattern/motion model
module tb_vga_pattern_ctrl_module;
    logic        vga_clk = 1'b0, rst_n = 1'b0;
    logic        ready = 1'b0, hs = 1'b1, vs = 1'b1, key = 1'b0;
    logic [10:0] col = '0, row = '0;
    logic [4:0]  r, b;
    logic [5:0]  g;
    logic        hso, vso;
    logic [1:0]  mode;
    int          total = 0, bad = 0;
    logic [19:0] q[$];
    int          m_mode, m_pend, m_vsp, m_x, m_y, m_vx, m_vy;
    localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                         16'hF81F, 16'hF800, 16'h001F, 16'h0000};

    always #5 vga_clk = ~vga_clk;

    vga_pattern_ctrl_module dut (
        .vga_clk(vga_clk), .rst_n(rst_n), .Ready_Sig(ready),
        .Column_Addr_Sig(col), .Row_Addr_Sig(row),
        .HSYNC_Sig(hs), .VSYNC_Sig(vs), .Key_Pulse_Sig(key),
        .Red_Sig(r), .Green_Sig(g), .Blue_Sig(b),
        .HSYNC_Out_Sig(hso), .VSYNC_Out_Sig(vso), .Mode_Sig(mode)
    );

    task automatic model_reset();
        m_mode = 0; m_pend = 0; m_vsp = 1;
        m_x = 0; m_y = 0; m_vx = 2; m_vy = 2;
    endtask

    function automatic logic [15:0] exp_rgb(bit rd, int c, int rw);
        if (!rd) return 16'h0000;
        if (m_mode == 0) return BARS[c / 100];
        if (m_mode == 1) return (c % 64 == 0 || rw % 64 == 0 || c == 799 || rw == 599) ? 16'hFFFF : 16'h0000;
        return (c >= m_x && c < m_x + 64 && rw >= m_y && rw < m_y + 64) ? 16'hF800 : 16'h001F;
    endfunction

    // move by the current velocity, stop at a wall and turn around there
    task automatic bounce(inout int p, inout int v, input int mx);
        p = p + v;
        if (p >= mx) begin p = mx; v = -2; end
        else if (p <= 0) begin p = 0; v = 2; end
    endtask

    function automatic int clampi(int v, int hi);
        return v < 0 ? 0 : (v > hi ? hi : v);
    endfunction

    task automatic drive(bit rd, int c, int rw, bit h, bit v, bit k);
        logic [15:0] e;
        @(posedge vga_clk); #1;
        ready = rd; col = rd ? 11'(c) : 11'd0; row = rd ? 11'(rw) : 11'd0;
        hs = h; vs = v; key = k;
        e = exp_rgb(rd, c, rw);
        if (m_vsp == 1 && !v) begin
            if (m_pend == 1 || k) begin m_mode = (m_mode + 1) % 3; m_pend = 0; end
            bounce(m_x, m_vx, 736);
            bounce(m_y, m_vy, 536);
        end else if (k) m_pend = 1;
        m_vsp = v;
        q.push_back({e, h, v, 2'(m_mode)});
    endtask

    task automatic frame(int npix, int nkeys, bit ktick, int nlow);
        int px[8], py[8];
        px = '{m_x - 1, m_x, m_x + 63, m_x + 64, m_x, m_x + 63, m_x + 32, m_x + 32};
        py = '{m_y, m_y, m_y + 63, m_y, m_y + 64, m_y - 1, m_y + 32, m_y + 64};
        for (int i = 0; i < npix; i++) begin
            bit kk = (i >= 10) && (i < 10 + 2 * nkeys) && (i % 2 == 1);
            bit hh = ($urandom % 4) != 0;
            if (i < 8) drive(1, clampi(px[i], 799), clampi(py[i], 599), hh, 1, kk);
            else if (($urandom % 5) == 0) drive(0, 0, 0, hh, 1, kk);
            else drive(1, $urandom % 800, $urandom % 600, hh, 1, kk);
        end
        drive(0, 0, 0, 1, 0, ktick);
        for (int j = 1; j < nlow; j++) drive(0, 0, 0, ($urandom % 2) != 0, 0, 0);
    endtask

    task automatic chk(string nm, logic [19:0] got, logic [19:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endtask

    // monitor: each cycle that follows a driven pixel yields one registered output
    initial forever begin
        logic [19:0] e;
        @(posedge vga_clk);
        if (q.size() > 0) begin
            e = q.pop_front();
            @(negedge vga_clk);
            chk("pixel {rgb,hs,vs,mode}", {r, g, b, hso, vso, mode}, e);
        end
    end

    initial begin
        model_reset();
        repeat (2) @(posedge vga_clk);
        #1 chk("reset_hold", {r, g, b, hso, vso, mode}, {16'h0000, 1'b1, 1'b1, 2'd0});
        @(negedge vga_clk) rst_n = 1'b1;
        drive(1, 0, 0, 1, 1, 0);
        drive(1, 99, 0, 0, 1, 0);
        drive(1, 100, 5, 1, 1, 0);
        drive(1, 799, 7, 0, 1, 0);
        drive(0, 300, 3, 1, 1, 0);
        drive(1, 150, 10, 0, 1, 0);
        drive(1, 150, 10, 0, 1, 0);
        drive(1, 150, 10, 1, 1, 0);
        frame(24, 3, 0, 3);
        drive(1, 64, 5, 1, 1, 0);
        drive(1, 65, 5, 1, 1, 0);
        drive(1, 799, 300, 1, 1, 0);
        drive(1, 10, 599, 1, 1, 0);
        frame(20, 0, 1, 2);
        for (int n = 0; n < 380; n++) frame(20 + int'($urandom % 8), 0, 0, 1 + int'($urandom % 3));
        frame(20, 0, 0, 40);
        frame(20, 0, 0, 2);
        for (int n = 0; n < 12; n++) frame(20, int'($urandom % 3), ($urandom % 2) != 0, 2);
        frame(20, 2, 0, 2);
        drive(1, 400, 300, 0, 1, 0);
        repeat (3) @(posedge vga_clk);
        #1 rst_n = 1'b0;
        #1 chk("reset_midline", {r, g, b, hso, vso, mode}, {16'h0000, 1'b1, 1'b1, 2'd0});
        model_reset();
        @(negedge vga_clk) rst_n = 1'b1;
        drive(1, 0, 0, 1, 1, 0);
        drive(1, 70, 70, 1, 1, 0);
        frame(20, 1, 0, 2);
        frame(20, 1, 0, 2);
        frame(20, 0, 0, 2);
        frame(20, 0, 0, 2);
        repeat (4) @(posedge vga_clk);
        if (q.size() != 0) chk("scoreboard_drain", 20'(q.size()), 20'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
